// File: rtl/inst_fetch.sv
// Instruction-fetch request stage: issues next_pc on the instruction bus, keeps
// one request outstanding, and buffers the returned word for decode.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hbfbf_fffc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        flush_i,
  output logic        pc_stall_o,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_adel_o
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [31:0] fetch_pc_r;
  logic        misaligned_s;
  logic        load_fetch_s;
  logic        load_adel_s;
  logic        load_data_s;
  logic        req_s;
  logic        stall_s;

  assign misaligned_s = (next_pc[1:0] != 2'b00);
  assign inst_addr    = next_pc;
  assign inst_req     = req_s;
  assign pc_stall_o   = stall_s;
  // The presented instruction is withdrawn in the very cycle a redirect arrives.
  assign id_valid_o   = rst & ~flush_i & (state_r == ST_HOLD);

  // Next-state, bus request and PC-stall decode.
  always_comb begin
    next_state_s = state_r;
    req_s        = 1'b0;
    stall_s      = 1'b1;
    load_fetch_s = 1'b0;
    load_adel_s  = 1'b0;
    load_data_s  = 1'b0;
    if (!rst) begin
      next_state_s = ST_REQ;
    end else if (flush_i) begin
      stall_s = 1'b0;
      case (state_r)
        ST_REQ:  next_state_s = ST_REQ;
        ST_HOLD: next_state_s = ST_REQ;
        ST_WAIT: next_state_s = inst_data_ok ? ST_REQ : ST_DROP;
        ST_DROP: next_state_s = inst_data_ok ? ST_REQ : ST_DROP;
        default: next_state_s = ST_REQ;
      endcase
    end else begin
      case (state_r)
        ST_REQ: begin
          if (misaligned_s) begin
            // AdEL: no bus access, the faulting PC goes straight to decode.
            stall_s      = 1'b0;
            load_adel_s  = 1'b1;
            next_state_s = ST_HOLD;
          end else begin
            req_s = 1'b1;
            if (inst_addr_ok) begin
              stall_s      = 1'b0;
              load_fetch_s = 1'b1;
              next_state_s = ST_WAIT;
            end else begin
              next_state_s = ST_REQ;
            end
          end
        end
        ST_WAIT: begin
          if (inst_data_ok) begin
            load_data_s  = 1'b1;
            next_state_s = ST_HOLD;
          end else begin
            next_state_s = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (id_ready_i) begin
            next_state_s = ST_REQ;
          end else begin
            next_state_s = ST_HOLD;
          end
        end
        ST_DROP: begin
          if (inst_data_ok) begin
            next_state_s = ST_REQ;
          end else begin
            next_state_s = ST_DROP;
          end
        end
        default: next_state_s = ST_REQ;
      endcase
    end
  end

  // State, outstanding-request PC and decode-facing output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_REQ;
      fetch_pc_r <= 32'h0000_0000;
      id_pc_o    <= RESET_PC;
      id_inst_o  <= 32'h0000_0000;
      id_adel_o  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (load_fetch_s) begin
        fetch_pc_r <= next_pc;
      end
      if (load_adel_s) begin
        id_pc_o   <= next_pc;
        id_inst_o <= 32'h0000_0000;
        id_adel_o <= 1'b1;
      end else if (load_data_s) begin
        id_pc_o   <= fetch_pc_r;
        id_inst_o <= inst_rdata;
        id_adel_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: stimulus pushes expected decode-side words into
// a queue, and a negedge monitor pops and compares on every decode handshake.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        flush_i;
  logic        pc_stall_o;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_adel_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  inst_fetch #(.RESET_PC(32'hbfbf_fffc)) dut (
    .clk          (clk),
    .rst          (rst),
    .next_pc      (next_pc),
    .flush_i      (flush_i),
    .pc_stall_o   (pc_stall_o),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .id_valid_o   (id_valid_o),
    .id_ready_i   (id_ready_i),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o),
    .id_adel_o    (id_adel_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
    exp_t e;
    e.pc = pc; e.inst = inst; e.adel = adel;
    exp_q.push_back(e);
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // check the combinational bus/stall outputs at the falling edge
  task automatic chk_bus(input string tag, input logic req, input logic stall, input logic valid);
    @(negedge clk);
    chk({tag, ".inst_req"}, {31'd0, inst_req}, {31'd0, req});
    chk({tag, ".pc_stall"}, {31'd0, pc_stall_o}, {31'd0, stall});
    chk({tag, ".id_valid"}, {31'd0, id_valid_o}, {31'd0, valid});
    if (req) chk({tag, ".inst_addr"}, inst_addr, next_pc);
  endtask

  // Scoreboard monitor: every decode handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && id_valid_o === 1'b1 && id_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_id: got pc %h inst %h adel %b expected no instruction",
                 id_pc_o, id_inst_o, id_adel_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb.id_pc", id_pc_o, e.pc);
        chk("sb.id_inst", id_inst_o, e.inst);
        chk("sb.id_adel", {31'd0, id_adel_o}, {31'd0, e.adel});
      end
    end
  end

  initial begin
    rst = 1'b0; next_pc = 32'h0; flush_i = 1'b0; inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0; inst_rdata = 32'h0; id_ready_i = 1'b0;

    // reset held for three edges
    cyc();
    chk_bus("rst", 1'b0, 1'b1, 1'b0);
    chk("rst.id_pc", id_pc_o, 32'hbfbf_fffc);
    chk("rst.id_inst", id_inst_o, 32'h0);
    chk("rst.id_adel", {31'd0, id_adel_o}, 32'h0);
    cyc(); cyc();

    // single fetch, data two cycles after address acceptance
    rst = 1'b1; next_pc = 32'hbfc0_0000; inst_addr_ok = 1'b1; id_ready_i = 1'b1;
    push(32'hbfc0_0000, 32'h3c08_bfaf, 1'b0);
    chk_bus("t1.req", 1'b1, 1'b0, 1'b0);
    cyc(); inst_addr_ok = 1'b0; next_pc = 32'hbfc0_0004;
    chk_bus("t1.wait0", 1'b0, 1'b1, 1'b0);
    cyc(); inst_data_ok = 1'b1; inst_rdata = 32'h3c08_bfaf;
    chk_bus("t1.data", 1'b0, 1'b1, 1'b0);
    cyc(); inst_data_ok = 1'b0; inst_rdata = 32'h0;
    chk_bus("t1.hold", 1'b0, 1'b1, 1'b1);

    // bus backpressure: four refused cycles, accepted on the fifth
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_bus("t2.stall", 1'b1, 1'b1, 1'b0);
    end
    cyc(); inst_addr_ok = 1'b1;
    push(32'hbfc0_0004, 32'h2408_0001, 1'b0);
    chk_bus("t2.accept", 1'b1, 1'b0, 1'b0);
    cyc(); inst_addr_ok = 1'b0; next_pc = 32'hbfc0_0008;
    inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001; id_ready_i = 1'b0;
    chk_bus("t2.data", 1'b0, 1'b1, 1'b0);

    // decode backpressure for five cycles in HOLD
    cyc(); inst_data_ok = 1'b0; inst_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      chk_bus("t3.hold", 1'b0, 1'b1, 1'b1);
      chk("t3.id_pc", id_pc_o, 32'hbfc0_0004);
      chk("t3.id_inst", id_inst_o, 32'h2408_0001);
    end
    cyc(); id_ready_i = 1'b1;
    chk_bus("t3.release", 1'b0, 1'b1, 1'b1);
    cyc();
    chk_bus("t3.req_next", 1'b1, 1'b1, 1'b0);

    // flush one cycle after address acceptance, data three cycles later
    cyc(); inst_addr_ok = 1'b1;
    chk_bus("t4.req", 1'b1, 1'b0, 1'b0);
    cyc(); inst_addr_ok = 1'b0; flush_i = 1'b1; next_pc = 32'hbfc0_0100;
    chk_bus("t4.flush", 1'b0, 1'b0, 1'b0);
    cyc(); flush_i = 1'b0;
    chk_bus("t4.drop0", 1'b0, 1'b1, 1'b0);
    cyc();
    chk_bus("t4.drop1", 1'b0, 1'b1, 1'b0);
    cyc(); inst_data_ok = 1'b1; inst_rdata = 32'hdead_beef;
    chk_bus("t4.drop_data", 1'b0, 1'b1, 1'b0);
    cyc(); inst_data_ok = 1'b0; inst_rdata = 32'h0; inst_addr_ok = 1'b1;
    push(32'hbfc0_0100, 32'h8c09_0010, 1'b0);
    chk_bus("t4.redirect", 1'b1, 1'b0, 1'b0);
    cyc(); inst_addr_ok = 1'b0; next_pc = 32'hbfc0_0104;
    inst_data_ok = 1'b1; inst_rdata = 32'h8c09_0010;
    chk_bus("t4.data", 1'b0, 1'b1, 1'b0);
    cyc(); inst_data_ok = 1'b0; inst_rdata = 32'h0;
    chk_bus("t4.hold", 1'b0, 1'b1, 1'b1);

    // flush coincident with data_ok in WAIT
    cyc(); next_pc = 32'hbfc0_0200; inst_addr_ok = 1'b1;
    chk_bus("t5.req", 1'b1, 1'b0, 1'b0);
    cyc(); inst_addr_ok = 1'b0; flush_i = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hcafe_0001;
    next_pc = 32'hbfc0_0300;
    chk_bus("t5.flush_data", 1'b0, 1'b0, 1'b0);
    cyc(); flush_i = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    chk_bus("t5.back_req", 1'b1, 1'b1, 1'b0);

    // misaligned PC: AdEL without a bus access, addr_ok ignored
    cyc(); next_pc = 32'hbfc0_0002; inst_addr_ok = 1'b1;
    push(32'hbfc0_0002, 32'h0000_0000, 1'b1);
    chk_bus("t6.misalign", 1'b0, 1'b0, 1'b0);
    cyc(); next_pc = 32'hbfc0_0400; inst_addr_ok = 1'b0;
    chk_bus("t6.hold", 1'b0, 1'b1, 1'b1);
    chk("t6.id_adel", {31'd0, id_adel_o}, 32'h1);

    // flush while HOLD gates the instruction away
    cyc(); inst_addr_ok = 1'b1;
    chk_bus("t7.req", 1'b1, 1'b0, 1'b0);
    cyc(); inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1111_2222;
    chk_bus("t7.data", 1'b0, 1'b1, 1'b0);
    cyc(); inst_data_ok = 1'b0; inst_rdata = 32'h0; flush_i = 1'b1;
    chk_bus("t7.flush_hold", 1'b0, 1'b0, 1'b0);
    cyc(); flush_i = 1'b0;
    chk_bus("t7.back_req", 1'b1, 1'b1, 1'b0);

    cyc();
    chk("sb.drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
